// File: rtl/arcade_input_ctrl.sv
// arcade_input_ctrl: merges PS/2 keyboard events and two joysticks into
// registered arcade controls and generates a fixed-length coin pulse.
// Optional feature macro: ARCADE_INPUT_ROTATE_EN enables the direction
// remap for horizontally rotated cabinets. Without it, the rotate input
// is ignored and directions pass straight through.
// The coin FSM state is exposed on coin_state for observation.
module arcade_input_ctrl #(
  parameter int unsigned COIN_PULSE_LEN = 600000
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic [10:0] ps2_key,
  input  logic [15:0] joy_0,
  input  logic [15:0] joy_1,
  input  logic        rotate,
  output logic        p1_up,
  output logic        p1_down,
  output logic        p1_left,
  output logic        p1_right,
  output logic        p1_fire,
  output logic        p2_up,
  output logic        p2_down,
  output logic        p2_left,
  output logic        p2_right,
  output logic        p2_fire,
  output logic        start1,
  output logic        start2,
  output logic        test,
  output logic        coin,
  output logic [1:0]  coin_state
);

  // Key latch indices. Codes that share a function share one latch,
  // so the latch follows the most recent event on either code.
  localparam int K_UP     = 0;
  localparam int K_DOWN   = 1;
  localparam int K_LEFT   = 2;
  localparam int K_RIGHT  = 3;
  localparam int K_FIRE   = 4;
  localparam int K_START1 = 5;
  localparam int K_START2 = 6;
  localparam int K_COIN1  = 7;
  localparam int K_COIN2  = 8;
  localparam int K_P2UP   = 9;
  localparam int K_P2DOWN = 10;
  localparam int K_P2LEFT = 11;
  localparam int K_P2RGHT = 12;
  localparam int K_P2FIRE = 13;
  localparam int K_TEST   = 14;
  localparam int NKEYS    = 15;

  localparam logic [23:0] PULSE_LAST = 24'(COIN_PULSE_LEN - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    HOLD  = 2'd2
  } coin_st_t;

  logic [1:0]       rst_sync;
  logic             rst_int_n;
  logic             strobe_q;
  logic             armed;
  logic             key_event;
  logic [NKEYS-1:0] key_latch;
  logic [NKEYS-1:0] key_nxt;

  logic raw1_up, raw1_down, raw1_left, raw1_right;
  logic raw2_up, raw2_down, raw2_left, raw2_right;
  logic d1_up, d1_down, d1_left, d1_right;
  logic d2_up, d2_down, d2_left, d2_right;
  logic fire1_d, fire2_d, start1_d, start2_d, test_d;
  logic coin_req;

  coin_st_t    state;
  logic [23:0] count;

  // Assert asynchronously, release two clocks after reset_n rises.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) rst_sync <= 2'b00;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_int_n = rst_sync[1];

  // Strobe copy; the first cycle after release only loads it (armed=0),
  // so a strobe level held through reset is never taken as an event.
  always_ff @(posedge clk_sys or negedge rst_int_n) begin
    if (!rst_int_n) begin
      strobe_q <= 1'b0;
      armed    <= 1'b0;
    end else begin
      strobe_q <= ps2_key[10];
      armed    <= 1'b1;
    end
  end

  assign key_event = armed & (ps2_key[10] ^ strobe_q);

  // Decode this cycle's key event into the next latch image (extended bit ignored).
  always_comb begin
    key_nxt = key_latch;
    if (key_event) begin
      case (ps2_key[7:0])
        8'h75:        key_nxt[K_UP]     = ps2_key[9];
        8'h72:        key_nxt[K_DOWN]   = ps2_key[9];
        8'h6B:        key_nxt[K_LEFT]   = ps2_key[9];
        8'h74:        key_nxt[K_RIGHT]  = ps2_key[9];
        8'h29, 8'h14: key_nxt[K_FIRE]   = ps2_key[9];
        8'h05, 8'h16: key_nxt[K_START1] = ps2_key[9];
        8'h06, 8'h1E: key_nxt[K_START2] = ps2_key[9];
        8'h2E:        key_nxt[K_COIN1]  = ps2_key[9];
        8'h36:        key_nxt[K_COIN2]  = ps2_key[9];
        8'h2D:        key_nxt[K_P2UP]   = ps2_key[9];
        8'h2B:        key_nxt[K_P2DOWN] = ps2_key[9];
        8'h23:        key_nxt[K_P2LEFT] = ps2_key[9];
        8'h34:        key_nxt[K_P2RGHT] = ps2_key[9];
        8'h1C:        key_nxt[K_P2FIRE] = ps2_key[9];
        8'h2C:        key_nxt[K_TEST]   = ps2_key[9];
        default:      key_nxt           = key_latch;
      endcase
    end
  end

  // Key latch storage.
  always_ff @(posedge clk_sys or negedge rst_int_n) begin
    if (!rst_int_n) key_latch <= '0;
    else            key_latch <= key_nxt;
  end

  // Raw controls: keyboard latch (next image) OR joystick bit.
  always_comb begin
    raw1_up    = key_nxt[K_UP]     | joy_0[3];
    raw1_down  = key_nxt[K_DOWN]   | joy_0[2];
    raw1_left  = key_nxt[K_LEFT]   | joy_0[1];
    raw1_right = key_nxt[K_RIGHT]  | joy_0[0];
    raw2_up    = key_nxt[K_P2UP]   | joy_1[3];
    raw2_down  = key_nxt[K_P2DOWN] | joy_1[2];
    raw2_left  = key_nxt[K_P2LEFT] | joy_1[1];
    raw2_right = key_nxt[K_P2RGHT] | joy_1[0];
    fire1_d    = key_nxt[K_FIRE]   | joy_0[4];
    fire2_d    = key_nxt[K_P2FIRE] | joy_1[4];
    start1_d   = key_nxt[K_START1] | joy_0[5] | joy_1[5];
    start2_d   = key_nxt[K_START2] | joy_0[6] | joy_1[6];
    test_d     = key_nxt[K_TEST];
  end

`ifdef ARCADE_INPUT_ROTATE_EN
  // Rotated cabinet: the stick is turned a quarter, so remap per player.
  always_comb begin
    if (rotate) begin
      d1_up = raw1_left;  d1_down = raw1_right; d1_left = raw1_down; d1_right = raw1_up;
      d2_up = raw2_left;  d2_down = raw2_right; d2_left = raw2_down; d2_right = raw2_up;
    end else begin
      d1_up = raw1_up;    d1_down = raw1_down;  d1_left = raw1_left; d1_right = raw1_right;
      d2_up = raw2_up;    d2_down = raw2_down;  d2_left = raw2_left; d2_right = raw2_right;
    end
  end
`else
  // Directions pass straight through; rotate has no effect in this build.
  always_comb begin
    d1_up = raw1_up;    d1_down = raw1_down;  d1_left = raw1_left; d1_right = raw1_right;
    d2_up = raw2_up;    d2_down = raw2_down;  d2_left = raw2_left; d2_right = raw2_right;
  end

  logic unused_rotate;
  assign unused_rotate = rotate;
`endif

  // Bits of the inputs that carry no function here.
  logic unused_bits;
  assign unused_bits = ^{ps2_key[8], joy_0[15:7], joy_1[15:7]};

  // Coin request uses the pre-register terms so it reacts in the same cycle.
  assign coin_req = key_nxt[K_COIN1] | key_nxt[K_COIN2] | start1_d | start2_d;

  // Registered control outputs.
  always_ff @(posedge clk_sys or negedge rst_int_n) begin
    if (!rst_int_n) begin
      p1_up    <= 1'b0;
      p1_down  <= 1'b0;
      p1_left  <= 1'b0;
      p1_right <= 1'b0;
      p1_fire  <= 1'b0;
      p2_up    <= 1'b0;
      p2_down  <= 1'b0;
      p2_left  <= 1'b0;
      p2_right <= 1'b0;
      p2_fire  <= 1'b0;
      start1   <= 1'b0;
      start2   <= 1'b0;
      test     <= 1'b0;
    end else begin
      p1_up    <= d1_up;
      p1_down  <= d1_down;
      p1_left  <= d1_left;
      p1_right <= d1_right;
      p1_fire  <= fire1_d;
      p2_up    <= d2_up;
      p2_down  <= d2_down;
      p2_left  <= d2_left;
      p2_right <= d2_right;
      p2_fire  <= fire2_d;
      start1   <= start1_d;
      start2   <= start2_d;
      test     <= test_d;
    end
  end

  // Coin FSM: one full-length pulse per request; HOLD waits for the
  // request to drop so a held button cannot retrigger.
  always_ff @(posedge clk_sys or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state <= IDLE;
      count <= '0;
      coin  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (coin_req) begin
            state <= PULSE;
            coin  <= 1'b1;
            count <= PULSE_LAST;
          end
        end
        PULSE: begin
          if (count == 24'd0) begin
            state <= HOLD;
            coin  <= 1'b0;
          end else begin
            count <= count - 24'd1;
          end
        end
        HOLD: begin
          if (!coin_req) state <= IDLE;
        end
        default: begin
          state <= IDLE;
          coin  <= 1'b0;
          count <= '0;
        end
      endcase
    end
  end

  assign coin_state = state;

endmodule

// File: tb/tb_arcade_input_ctrl.sv
// Bench for arcade_input_ctrl with COIN_PULSE_LEN=4.
module tb_arcade_input_ctrl;

  localparam int LEN = 4;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic [10:0] ps2_key = '0;
  logic [15:0] joy_0 = '0;
  logic [15:0] joy_1 = '0;
  logic        rotate = 1'b0;
  logic p1_up, p1_down, p1_left, p1_right, p1_fire;
  logic p2_up, p2_down, p2_left, p2_right, p2_fire;
  logic start1, start2, test, coin;
  logic [1:0] coin_state;

  int n_tests = 0;
  int n_fail  = 0;
  bit started = 0;

  arcade_input_ctrl #(.COIN_PULSE_LEN(LEN)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .ps2_key(ps2_key),
    .joy_0(joy_0), .joy_1(joy_1), .rotate(rotate),
    .p1_up(p1_up), .p1_down(p1_down), .p1_left(p1_left), .p1_right(p1_right), .p1_fire(p1_fire),
    .p2_up(p2_up), .p2_down(p2_down), .p2_left(p2_left), .p2_right(p2_right), .p2_fire(p2_fire),
    .start1(start1), .start2(start2), .test(test), .coin(coin), .coin_state(coin_state)
  );

  // Clock
  always #5 clk_sys = ~clk_sys;

  function automatic logic [13:0] act_vec();
    return {p1_up, p1_down, p1_left, p1_right, p1_fire,
            p2_up, p2_down, p2_left, p2_right, p2_fire,
            start1, start2, test, coin};
  endfunction

  // ---------------- behavioural model ----------------
  // Function index per scan code (extended bit dropped), -1 = no function.
  function automatic int key_func(input logic [7:0] code);
    case (code)
      8'h75: return 0;   8'h72: return 1;   8'h6B: return 2;   8'h74: return 3;
      8'h29, 8'h14: return 4;
      8'h05, 8'h16: return 5;
      8'h06, 8'h1E: return 6;
      8'h2E: return 7;   8'h36: return 8;
      8'h2D: return 9;   8'h2B: return 10;  8'h23: return 11;  8'h34: return 12;
      8'h1C: return 13;  8'h2C: return 14;
      default: return -1;
    endcase
  endfunction

  bit          m_key[15];
  bit          m_strobe = 0;
  int          m_edges = 0;     // clock edges seen since reset_n went high
  int          m_left = 0;      // coin cycles still to output
  bit          m_wait_drop = 0; // pulse done, waiting for request to drop
  logic [13:0] exp_v = '0;

  always @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      foreach (m_key[i]) m_key[i] = 0;
      m_strobe = 0; m_edges = 0; m_left = 0; m_wait_drop = 0; exp_v = '0;
    end else if (m_edges < 2) begin
      m_edges++;
    end else begin
      bit u, d, l, r, f1, f2, s1, s2, req;
      bit q_u, q_d, q_l, q_r;
      int fn;
      if (m_edges >= 3 && ps2_key[10] != m_strobe) begin
        fn = key_func(ps2_key[7:0]);
        if (fn >= 0) m_key[fn] = ps2_key[9];
      end
      m_strobe = ps2_key[10];
      m_edges = 3;
      u = m_key[0] | joy_0[3]; d = m_key[1] | joy_0[2];
      l = m_key[2] | joy_0[1]; r = m_key[3] | joy_0[0];
      q_u = m_key[9] | joy_1[3];  q_d = m_key[10] | joy_1[2];
      q_l = m_key[11] | joy_1[1]; q_r = m_key[12] | joy_1[0];
`ifdef ARCADE_INPUT_ROTATE_EN
      if (rotate) begin
        {u, d, l, r} = {l, r, d, u};
        {q_u, q_d, q_l, q_r} = {q_l, q_r, q_d, q_u};
      end
`endif
      f1 = m_key[4] | joy_0[4];
      f2 = m_key[13] | joy_1[4];
      s1 = m_key[5] | joy_0[5] | joy_1[5];
      s2 = m_key[6] | joy_0[6] | joy_1[6];
      req = m_key[7] | m_key[8] | s1 | s2;
      if (m_left > 0) m_left--;
      else if (m_wait_drop) begin
        if (!req) m_wait_drop = 0;
      end else if (req) begin
        m_left = LEN;
        m_wait_drop = 1;
      end
      exp_v = {u, d, l, r, f1, q_u, q_d, q_l, q_r, f2, s1, s2, m_key[14], m_left > 0};
    end
  end

  // Per-cycle compare against the model
  always @(negedge clk_sys) begin
    if (started) begin
      n_tests++;
      if (act_vec() !== exp_v) begin
        n_fail++;
        $display("FAIL model_cmp @%0t: outputs %b, model requires %b", $time, act_vec(), exp_v);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic key(input logic [8:0] code9, input logic pressed);
    ps2_key = {~ps2_key[10], pressed, code9};
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic count_coin(input int cycles, output int highs, output int rises);
    logic prev;
    prev = coin;
    highs = 0;
    rises = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (coin) highs++;
      if (coin && !prev) rises++;
      prev = coin;
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int h, r, h2;
    bit any;
    repeat (3) tick();
    started = 1;
    check("reset_outputs", {18'd0, act_vec()}, 32'd0);
    check("reset_state", {30'd0, coin_state}, 32'd0);
    reset_n = 1;
    repeat (4) tick();

    // press / release up
    key(9'h075, 1); tick();
    check("p1_up_press", {31'd0, p1_up}, 32'd1);
    tick();
    check("p1_up_hold", {31'd0, p1_up}, 32'd1);
    key(9'h075, 0); tick();
    check("p1_up_release", {31'd0, p1_up}, 32'd0);

    // extended bit ignored
    key(9'h172, 1); tick();
    check("ext_down_press", {31'd0, p1_down}, 32'd1);
    key(9'h172, 0); tick();
    check("ext_down_release", {31'd0, p1_down}, 32'd0);

    // shared start1 latch follows the latest event
    key(9'h005, 1); tick();
    key(9'h016, 1); tick();
    key(9'h005, 0); tick();
    check("shared_latch", {31'd0, start1}, 32'd0);
    repeat (10) tick();

    // unknown code changes nothing
    key(9'h055, 1); tick();
    check("unknown_code", {18'd0, act_vec()}, 32'd0);

    // player-2 keys and test
    key(9'h02D, 1); tick();
    key(9'h01C, 1); tick();
    key(9'h02C, 1); tick();
    check("p2_keys", {29'd0, p2_up, p2_fire, test}, 32'h7);
    key(9'h02D, 0); tick();
    key(9'h01C, 0); tick();
    key(9'h02C, 0); tick();
    check("p2_keys_release", {29'd0, p2_up, p2_fire, test}, 32'h0);

    // rotation of joystick left
    rotate = 1; joy_0 = 16'h0002; tick();
`ifdef ARCADE_INPUT_ROTATE_EN
    check("rotate_left", {30'd0, p1_up, p1_left}, 32'h2);
`else
    check("rotate_left", {30'd0, p1_up, p1_left}, 32'h1);
`endif
    joy_0 = '0; rotate = 0; tick();
    joy_1 = 16'h0018; tick();
    check("joy1_up_fire", {30'd0, p2_up, p2_fire}, 32'h3);
    joy_1 = 16'hFF80; tick();
    check("joy_high_bits", {18'd0, act_vec()}, 32'd0);
    joy_1 = '0;
    repeat (4) tick();

    // coin key held 20 cycles, then a second press
    key(9'h02E, 1); count_coin(20, h, r);
    check("coin1_highs", h, 4);
    check("coin1_pulses", r, 1);
    key(9'h02E, 0); count_coin(6, h, r);
    check("coin1_release", h, 0);
    key(9'h02E, 1); count_coin(20, h, r);
    check("coin2_highs", h, 4);
    check("coin2_pulses", r, 1);
    key(9'h02E, 0); repeat (6) tick();

    // one-cycle start1 from joystick 2
    joy_1 = 16'h0020; tick();
    check("start1_pulse_on", {31'd0, start1}, 32'd1);
    h2 = int'(coin);
    joy_1 = '0; tick();
    check("start1_pulse_off", {31'd0, start1}, 32'd0);
    h2 += int'(coin);
    count_coin(10, h, r);
    check("start1_coin_highs", h + h2, 4);

    // strobe held high through reset release: no event
    reset_n = 0;
    ps2_key = 11'h629;
    tick(); tick();
    reset_n = 1;
    any = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (p1_fire) any = 1;
    end
    check("fire_through_reset", {31'd0, any}, 32'd0);
    key(9'h029, 0); tick();
    check("fire_after_release", {31'd0, p1_fire}, 32'd0);
    repeat (4) tick();

    // reset during pulse, request not held afterwards
    key(9'h02E, 1); tick(); tick();
    check("pulse_running", {31'd0, coin}, 32'd1);
    reset_n = 0; #1;
    check("reset_abort_coin", {31'd0, coin}, 32'd0);
    tick(); tick();
    reset_n = 1;
    count_coin(12, h, r);
    check("no_residual_pulse", h, 0);

    // reset during pulse with start1 held: fresh full pulse
    joy_0 = 16'h0020; tick(); tick();
    reset_n = 0; tick();
    reset_n = 1;
    count_coin(16, h, r);
    check("fresh_pulse_highs", h, 4);
    joy_0 = '0; repeat (6) tick();

    started = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
